lbus_host_bridge: RTL



---
 rtl/lbus_host_bridge.sv | 125 ++++++++++++
 1 files changed

// File: rtl/lbus_host_bridge.sv
// Host byte-stream command decoder and 16-bit local-bus master.
// Executes write/read bus cycles with fixed strobe timing and returns read data as two bytes.
module lbus_host_bridge #(
    parameter int unsigned WR_HOLD = 4,
    parameter int unsigned WR_GAP  = 3,
    parameter int unsigned RD_WAIT = 3,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [15:0] lbus_a,
    output logic [15:0] lbus_di,
    input  logic [15:0] lbus_do,
    output logic        lbus_wr,
    output logic        lbus_rd,
    output logic        busy,
    output logic        cmd_err
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR_H, S_ADDR_L, S_DATA_H, S_DATA_L,
        S_WR_ASSERT, S_WR_GAP, S_RD_OPEN, S_RD_CAPT, S_TX_H, S_TX_L
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        mode_wr;
    logic [15:0] gap_cnt;
    logic [7:0]  phase_cnt;
    logic [7:0]  rdata_lo;
    logic        rx_take;
    logic        tx_take;
    logic        rx_wait;
    logic        gap_expire;
    logic        bad_op;

    function automatic logic is_rx(input state_t s);
        return (s == S_IDLE) || (s == S_ADDR_H) || (s == S_ADDR_L) ||
               (s == S_DATA_H) || (s == S_DATA_L);
    endfunction

    assign rx_take    = rx_valid & rx_ready;
    assign tx_take    = tx_valid & tx_ready;
    // Inter-byte timeout only runs while a command is partially received
    assign rx_wait    = is_rx(state) && (state != S_IDLE);
    assign gap_expire = (gap_cnt == 16'(TIMEOUT - 1));
    assign bad_op     = (state == S_IDLE) && rx_take && (rx_data[7:1] != 7'd0);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (rx_take && rx_data[7:1] == 7'd0) state_nxt = S_ADDR_H;
            S_ADDR_H:    if (rx_take) state_nxt = S_ADDR_L;
                         else if (gap_expire) state_nxt = S_IDLE;
            S_ADDR_L:    if (rx_take) state_nxt = mode_wr ? S_DATA_H : S_RD_OPEN;
                         else if (gap_expire) state_nxt = S_IDLE;
            S_DATA_H:    if (rx_take) state_nxt = S_DATA_L;
                         else if (gap_expire) state_nxt = S_IDLE;
            S_DATA_L:    if (rx_take) state_nxt = S_WR_ASSERT;
                         else if (gap_expire) state_nxt = S_IDLE;
            S_WR_ASSERT: if (phase_cnt == 8'(WR_HOLD - 1)) state_nxt = S_WR_GAP;
            S_WR_GAP:    if (phase_cnt == 8'(WR_GAP - 1)) state_nxt = S_IDLE;
            S_RD_OPEN:   if (phase_cnt == 8'(RD_WAIT - 1)) state_nxt = S_RD_CAPT;
            S_RD_CAPT:   state_nxt = S_TX_H;
            S_TX_H:      if (tx_take) state_nxt = S_TX_L;
            S_TX_L:      if (tx_take) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Strobes and handshake flags are registered from the next state so they align with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            mode_wr   <= 1'b0;
            gap_cnt   <= '0;
            phase_cnt <= '0;
            rdata_lo  <= '0;
            rx_ready  <= 1'b0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            lbus_a    <= '0;
            lbus_di   <= '0;
            lbus_wr   <= 1'b0;
            lbus_rd   <= 1'b1;
            busy      <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            rx_ready  <= is_rx(state_nxt);
            busy      <= (state_nxt != S_IDLE);
            lbus_wr   <= (state_nxt == S_WR_ASSERT);
            lbus_rd   <= (state_nxt != S_RD_OPEN);
            tx_valid  <= (state_nxt == S_TX_H) || (state_nxt == S_TX_L);
            cmd_err   <= bad_op || (rx_wait && !rx_take && gap_expire);
            gap_cnt   <= (rx_wait && !rx_take) ? gap_cnt + 16'd1 : '0;
            phase_cnt <= (state_nxt != state) ? '0 : phase_cnt + 8'd1;

            if (rx_take) begin
                case (state)
                    S_IDLE:   mode_wr       <= rx_data[0];
                    S_ADDR_H: lbus_a[15:8]  <= rx_data;
                    S_ADDR_L: lbus_a[7:0]   <= rx_data;
                    S_DATA_H: lbus_di[15:8] <= rx_data;
                    S_DATA_L: lbus_di[7:0]  <= rx_data;
                    default:  ;
                endcase
            end

            if (state == S_RD_CAPT) begin
                rdata_lo <= lbus_do[7:0];
                tx_data  <= lbus_do[15:8];
            end
            if (state == S_TX_H && tx_take)
                tx_data <= rdata_lo;
        end
    end

endmodule
